sync_fifo_fwft: RTL and testbench

- Single-clock, parametrised successor to the link-path FIFO. Buffers DATA_WIDTH words between producer and consumer stages in the same clock domain, e.g. frame packer to serializer on clk.
- Adds a selectable first-word-fall-through (FWFT) or standard read mode, programmable almost-full/almost-empty thresholds, and an exact fill level.
- Adds sticky overflow/underflow error flags with a clear input.

---
 rtl/sync_fifo_fwft.sv | 121 ++++++++++++
 tb/tb_sync_fifo_fwft.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock FIFO with FWFT/standard read, thresholds, fill level and sticky errors
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   wr_en, wr_data           push request and data
//   wr_full, wr_almost_full  level == DEPTH, level >= AF_THRESH
//   rd_en                    pop request (FWFT: acknowledges the presented word)
//   rd_data, rd_valid        read data and its qualifier
//   rd_empty, rd_almost_empty level == 0, level <= AE_THRESH
//   level                    stored word count, 0..DEPTH
//   overflow, underflow      sticky error flags
//   clr_err                  clears both error flags (a same-cycle set wins)
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter bit FWFT       = 1'b1,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH + 1)'(AE_THRESH);

  if (ADDR_WIDTH < 1) begin : g_bad_addr
    $error("sync_fifo_fwft: ADDR_WIDTH must give a depth of at least 2");
  end
  if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_fwft: AF_THRESH outside 0..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
    $error("sync_fifo_fwft: AE_THRESH outside 0..DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_nxt;
  logic                  push;
  logic                  pop;

  // Accept decisions use only registered status, so a same-cycle pop never
  // frees room for a push into a full FIFO (and vice versa when empty).
  assign push = wr_en & ~wr_full;
  assign pop  = rd_en & ~rd_empty;

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // Status flags are registered from the next level so they change exactly
  // with level and are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      wr_full         <= 1'b0;
      wr_almost_full  <= 1'b0;
      rd_empty        <= 1'b1;
      rd_almost_empty <= 1'b1;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level           <= level_nxt;
      wr_full         <= (level_nxt == DEPTH_L);
      wr_almost_full  <= (level_nxt >= AF_L);
      rd_empty        <= (level_nxt == '0);
      rd_almost_empty <= (level_nxt <= AE_L);
      // Set has priority over clear.
      overflow        <= (overflow  & ~clr_err) | (wr_en & wr_full);
      underflow       <= (underflow & ~clr_err) | (rd_en & rd_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  if (FWFT) begin : g_fwft
    // Head word is shown directly; forced to zero while empty so the output
    // is deterministic after reset regardless of memory contents.
    assign rd_valid = ~rd_empty;
    assign rd_data  = rd_empty ? '0 : mem[rd_ptr];
  end else begin : g_std
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= pop;
        if (pop) rd_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb/tb_sync_fifo_fwft.sv - self-checking bench for sync_fifo_fwft in FWFT and standard modes
module tb_sync_fifo_fwft;

  logic clk;
  int   errors;
  int   checks;

  // FWFT instance, default depth 64
  logic        f_rst, f_wr_en, f_rd_en, f_clr;
  logic [31:0] f_wr_data, f_rd_data;
  logic        f_full, f_af, f_valid, f_empty, f_ae, f_ovf, f_unf;
  logic [6:0]  f_level;

  // Standard-read instance, depth 8
  logic        s_rst, s_wr_en, s_rd_en, s_clr;
  logic [31:0] s_wr_data, s_rd_data;
  logic        s_full, s_af, s_valid, s_empty, s_ae, s_ovf, s_unf;
  logic [3:0]  s_level;

  logic [31:0] f_q[$];
  logic [31:0] s_q[$];

  sync_fifo_fwft #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .FWFT(1'b1)) dut_f (
    .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .wr_full(f_full), .wr_almost_full(f_af), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_valid), .rd_empty(f_empty),
    .rd_almost_empty(f_ae), .level(f_level), .overflow(f_ovf),
    .underflow(f_unf), .clr_err(f_clr)
  );

  sync_fifo_fwft #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .FWFT(1'b0)) dut_s (
    .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .wr_full(s_full), .wr_almost_full(s_af), .rd_en(s_rd_en),
    .rd_data(s_rd_data), .rd_valid(s_valid), .rd_empty(s_empty),
    .rd_almost_empty(s_ae), .level(s_level), .overflow(s_ovf),
    .underflow(s_unf), .clr_err(s_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    f_rst = 1'b1; s_rst = 1'b1;
    f_wr_en = 0; f_rd_en = 0; f_clr = 0; f_wr_data = '0;
    s_wr_en = 0; s_rd_en = 0; s_clr = 0; s_wr_data = '0;
    tick(); tick();
    f_rst = 1'b0; s_rst = 1'b0;
    tick();
    checks++; if (f_level !== 7'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", f_level); end
    checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", f_empty); end
    checks++; if (f_ae !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b want=1", f_ae); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", f_valid); end
    checks++; if (f_full !== 1'b0 || f_af !== 1'b0) begin errors++; $display("FAIL reset_full got=%b%b want=00", f_full, f_af); end
    checks++; if (f_ovf !== 1'b0 || f_unf !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b want=00", f_ovf, f_unf); end
    checks++; if (f_rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got=%h want=0", f_rd_data); end
    checks++; if (s_level !== 4'd0 || s_empty !== 1'b1 || s_valid !== 1'b0 || s_rd_data !== 32'd0) begin
      errors++; $display("FAIL reset_std got=%0d/%b/%b/%h want=0/1/0/0", s_level, s_empty, s_valid, s_rd_data);
    end
  endtask

  task automatic test_fwft_single;
    logic [31:0] exp;
    f_wr_en = 1'b1; f_wr_data = 32'hA5A5_0001; f_q.push_back(f_wr_data);
    tick();
    f_wr_en = 1'b0;
    exp = f_q[0];
    checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL fwft_valid got=%b want=1", f_valid); end
    checks++; if (f_rd_data !== exp) begin errors++; $display("FAIL fwft_data got=%h want=%h", f_rd_data, exp); end
    checks++; if (f_level !== 7'd1) begin errors++; $display("FAIL fwft_level got=%0d want=1", f_level); end
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    void'(f_q.pop_front());
    checks++; if (f_empty !== 1'b1 || f_valid !== 1'b0) begin errors++; $display("FAIL fwft_pop_empty got=%b/%b want=1/0", f_empty, f_valid); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 8; i++) begin
      s_wr_en = 1'b1; s_wr_data = i; s_q.push_back(s_wr_data);
      tick();
      checks++; if (s_level !== 4'(i + 1)) begin errors++; $display("FAIL fill_level got=%0d want=%0d", s_level, i + 1); end
      checks++; if (s_af !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_af lvl=%0d got=%b want=%b", i + 1, s_af, (i + 1 >= 6)); end
      checks++; if (s_full !== (i + 1 == 8)) begin errors++; $display("FAIL fill_full lvl=%0d got=%b want=%b", i + 1, s_full, (i + 1 == 8)); end
      checks++; if (s_ae !== (i + 1 <= 2)) begin errors++; $display("FAIL fill_ae lvl=%0d got=%b want=%b", i + 1, s_ae, (i + 1 <= 2)); end
    end
    s_wr_data = 32'h99;
    tick();
    s_wr_en = 1'b0;
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", s_ovf); end
    checks++; if (s_level !== 4'd8) begin errors++; $display("FAIL ovf_level got=%0d want=8", s_level); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      s_rd_en = 1'b1;
      tick();
      exp = s_q.pop_front();
      checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid i=%0d got=%b want=1", i, s_valid); end
      checks++; if (s_rd_data !== exp) begin errors++; $display("FAIL b2b_data i=%0d got=%h want=%h", i, s_rd_data, exp); end
      checks++; if (s_level !== 4'(7 - i)) begin errors++; $display("FAIL b2b_level got=%0d want=%0d", s_level, 7 - i); end
    end
    s_rd_en = 1'b0;
    tick();
    checks++; if (s_valid !== 1'b0 || s_rd_data !== 32'd7) begin errors++; $display("FAIL b2b_hold got=%b/%h want=0/7", s_valid, s_rd_data); end
    checks++; if (s_empty !== 1'b1 || s_unf !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b/%b want=1/0", s_empty, s_unf); end
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", s_ovf); end
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b want=0", s_ovf); end
  endtask

  task automatic test_simultaneous;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      s_wr_en = 1'b1; s_wr_data = 32'h100 + i; s_q.push_back(s_wr_data);
      tick();
    end
    s_wr_data = 32'hDEAD; s_rd_en = 1'b1;
    tick();
    s_wr_en = 1'b0;
    exp = s_q.pop_front();
    checks++; if (s_level !== 4'd7) begin errors++; $display("FAIL full_pp_level got=%0d want=7", s_level); end
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL full_pp_ovf got=%b want=1", s_ovf); end
    checks++; if (s_rd_data !== exp || s_valid !== 1'b1) begin errors++; $display("FAIL full_pp_data got=%h want=%h", s_rd_data, exp); end
    for (int i = 0; i < 7; i++) begin
      tick();
      exp = s_q.pop_front();
      checks++; if (s_rd_data !== exp) begin errors++; $display("FAIL full_pp_drain got=%h want=%h", s_rd_data, exp); end
    end
    s_rd_en = 1'b0; s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 32'h55; s_q.push_back(s_wr_data);
    tick();
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    checks++; if (s_level !== 4'd1) begin errors++; $display("FAIL empty_pp_level got=%0d want=1", s_level); end
    checks++; if (s_unf !== 1'b1 || s_ovf !== 1'b0) begin errors++; $display("FAIL empty_pp_flags got=%b/%b want=1/0", s_unf, s_ovf); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL empty_pp_valid got=%b want=0", s_valid); end
    s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
    exp = s_q.pop_front();
    checks++; if (s_rd_data !== exp || s_valid !== 1'b1) begin errors++; $display("FAIL empty_pp_data got=%h want=%h", s_rd_data, exp); end
    checks++; if (s_unf !== 1'b1) begin errors++; $display("FAIL unf_sticky got=%b want=1", s_unf); end
  endtask

  task automatic test_stream;
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      f_wr_en = 1'b1; f_wr_data = 32'hC000 + i; f_q.push_back(f_wr_data);
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      exp = f_q[0];
      checks++; if (f_rd_data !== exp || f_valid !== 1'b1) begin errors++; $display("FAIL stream_data i=%0d got=%h want=%h", i, f_rd_data, exp); end
      f_wr_en = 1'b1; f_rd_en = 1'b1; f_wr_data = $urandom; f_q.push_back(f_wr_data);
      tick();
      void'(f_q.pop_front());
      checks++; if (f_level !== 7'd3) begin errors++; $display("FAIL stream_level i=%0d got=%0d want=3", i, f_level); end
    end
    f_wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = f_q[0];
      checks++; if (f_rd_data !== exp) begin errors++; $display("FAIL stream_drain got=%h want=%h", f_rd_data, exp); end
      tick();
      void'(f_q.pop_front());
    end
    f_rd_en = 1'b0;
    checks++; if (f_empty !== 1'b1 || f_unf !== 1'b0) begin errors++; $display("FAIL stream_end got=%b/%b want=1/0", f_empty, f_unf); end
  endtask

  task automatic test_clr_vs_set;
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    checks++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin errors++; $display("FAIL clr_both got=%b/%b want=0/0", s_ovf, s_unf); end
    for (int i = 0; i < 8; i++) begin
      s_wr_en = 1'b1; s_wr_data = i;
      tick();
    end
    checks++; if (s_ovf !== 1'b0 || s_full !== 1'b1) begin errors++; $display("FAIL clr_pre got=%b/%b want=0/1", s_ovf, s_full); end
    s_clr = 1'b1;
    tick();
    s_wr_en = 1'b0; s_clr = 1'b0;
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL set_wins got=%b want=1", s_ovf); end
  endtask

  task automatic test_mid_reset;
    logic [31:0] exp;
    for (int i = 0; i < 5; i++) begin
      f_wr_en = 1'b1; f_wr_data = 32'hEE00 + i;
      tick();
    end
    f_wr_en = 1'b0;
    checks++; if (f_level !== 7'd5) begin errors++; $display("FAIL pre_reset_level got=%0d want=5", f_level); end
    f_rst = 1'b1;
    tick();
    f_rst = 1'b0;
    f_q.delete();
    checks++; if (f_level !== 7'd0 || f_empty !== 1'b1 || f_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got=%0d/%b/%b want=0/1/0", f_level, f_empty, f_valid);
    end
    f_wr_en = 1'b1; f_wr_data = 32'hBEEF_0001; f_q.push_back(f_wr_data);
    tick();
    f_wr_en = 1'b0;
    exp = f_q[0];
    checks++; if (f_rd_data !== exp || f_level !== 7'd1) begin errors++; $display("FAIL post_reset_data got=%h/%0d want=%h/1", f_rd_data, f_level, exp); end
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    void'(f_q.pop_front());
    checks++; if (f_empty !== 1'b1 || f_valid !== 1'b0) begin errors++; $display("FAIL post_reset_empty got=%b/%b want=1/0", f_empty, f_valid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fwft_single();
    test_fill();
    test_back_to_back();
    test_simultaneous();
    test_stream();
    test_clr_vs_set();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
